// File: rtl/fdc_bus_ctrl.sv
// uPD765 bus sequencer for the +3 ports #2FFD/#3FFD: timed CS/A0/RD/WR strobes, read latch and CPU WAIT.
// Optional macro FDC_WAIT_EN: drive wait_n low while an access is in flight; otherwise wait_n is tied high.
`timescale 1ns/1ps
module fdc_bus_ctrl #(
  parameter int SETUP_CYC    = 2,
  parameter int STROBE_CYC   = 7,
  parameter int HOLD_CYC     = 2,
  parameter int RECOVERY_CYC = 14
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        en,
  input  logic        ioreq,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] a,
  input  logic [7:0]  d_in,
  input  logic [7:0]  fdc_d_in,
  output logic [7:0]  fdc_d_out,
  output logic        fdc_d_oe,
  output logic        fdc_cs_n,
  output logic        fdc_a0,
  output logic        fdc_rd_n,
  output logic        fdc_wr_n,
  output logic [7:0]  d_out,
  output logic        d_out_active,
  output logic        wait_n
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  // Phase lengths are 1..15; the counter is loaded with length-1 on entry.
  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOVER_LD = 4'(RECOVERY_CYC - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        req, req_q, req_edge, last;
  logic        dir_rd;
  logic        pend, pend_rd, pend_a0;
  logic [7:0]  pend_d;
  logic        start_cur, start_pend;
  logic        nxt_rd, nxt_a0;
  logic [7:0]  nxt_d;
  logic        unused_addr;

  assign req         = en & ioreq & (a[15:13] == 3'b001) & ~a[1] & (rd ^ wr);
  assign req_edge    = req & ~req_q;
  assign last        = (cnt == 4'd0);
  assign unused_addr = ^{a[11:2], a[0]};

  // A fresh edge may start directly only if nothing is queued behind the current access.
  assign start_pend = (state == RECOVER) && last && pend;
  assign start_cur  = req_edge && ((state == IDLE) || ((state == RECOVER) && last && !pend));

  always_comb begin
    nxt_rd = rd;
    nxt_a0 = a[12];
    nxt_d  = d_in;
    if (start_pend) begin
      nxt_rd = pend_rd;
      nxt_a0 = pend_a0;
      nxt_d  = pend_d;
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      req_q        <= 1'b0;
      dir_rd       <= 1'b0;
      pend         <= 1'b0;
      pend_rd      <= 1'b0;
      pend_a0      <= 1'b0;
      pend_d       <= 8'h00;
      fdc_cs_n     <= 1'b1;
      fdc_rd_n     <= 1'b1;
      fdc_wr_n     <= 1'b1;
      fdc_a0       <= 1'b0;
      fdc_d_oe     <= 1'b0;
      fdc_d_out    <= 8'h00;
      d_out        <= 8'h00;
      d_out_active <= 1'b0;
      wait_n       <= 1'b1;
    end else begin
      req_q <= req;
      if (start_cur || start_pend) begin
        state        <= SETUP;
        cnt          <= SETUP_LD;
        dir_rd       <= nxt_rd;
        fdc_a0       <= nxt_a0;
        fdc_cs_n     <= 1'b0;
        fdc_d_oe     <= ~nxt_rd;
        d_out_active <= 1'b0;
        pend         <= 1'b0;
        if (!nxt_rd)
          fdc_d_out <= nxt_d;
`ifdef FDC_WAIT_EN
        wait_n <= 1'b0;
`endif
      end else begin
        if (!req)
          d_out_active <= 1'b0;
        case (state)
          IDLE: cnt <= 4'd0;
          SETUP:
            if (last) begin
              state    <= STROBE;
              cnt      <= STROBE_LD;
              fdc_rd_n <= ~dir_rd;
              fdc_wr_n <= dir_rd;
            end else cnt <= cnt - 4'd1;
          STROBE:
            if (last) begin
              state    <= HOLD;
              cnt      <= HOLD_LD;
              fdc_rd_n <= 1'b1;
              fdc_wr_n <= 1'b1;
`ifdef FDC_WAIT_EN
              wait_n   <= 1'b1;
`endif
              if (dir_rd) begin
                d_out        <= fdc_d_in;
                d_out_active <= 1'b1;
              end
            end else cnt <= cnt - 4'd1;
          HOLD:
            if (last) begin
              state    <= RECOVER;
              cnt      <= RECOVER_LD;
              fdc_cs_n <= 1'b1;
              fdc_d_oe <= 1'b0;
            end else cnt <= cnt - 4'd1;
          RECOVER:
            if (last) state <= IDLE;
            else      cnt   <= cnt - 4'd1;
          default: state <= IDLE;
        endcase
        // One-deep queue: a later edge while one is already queued is lost.
        if (req_edge && !pend && ((state == HOLD) || ((state == RECOVER) && !last))) begin
          pend    <= 1'b1;
          pend_rd <= rd;
          pend_a0 <= a[12];
          pend_d  <= d_in;
`ifdef FDC_WAIT_EN
          wait_n  <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_fdc_bus_ctrl.sv
// Scoreboard bench for fdc_bus_ctrl: expected accesses are queued at drive time, checked at CS release.
`timescale 1ns/1ps
module tb_fdc_bus_ctrl;

  logic        clk28 = 1'b0, rst = 1'b1, en = 1'b0, ioreq = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [7:0]  d_in = 8'h00, fdc_d_in = 8'h00;
  logic [7:0]  fdc_d_out, d_out;
  logic        fdc_d_oe, fdc_cs_n, fdc_a0, fdc_rd_n, fdc_wr_n, d_out_active, wait_n;

  fdc_bus_ctrl dut (
    .clk28(clk28), .rst(rst), .en(en), .ioreq(ioreq), .rd(rd), .wr(wr), .a(a),
    .d_in(d_in), .fdc_d_in(fdc_d_in), .fdc_d_out(fdc_d_out), .fdc_d_oe(fdc_d_oe),
    .fdc_cs_n(fdc_cs_n), .fdc_a0(fdc_a0), .fdc_rd_n(fdc_rd_n), .fdc_wr_n(fdc_wr_n),
    .d_out(d_out), .d_out_active(d_out_active), .wait_n(wait_n)
  );

  always #18 clk28 = ~clk28;

  int cyc = 0;
  always @(posedge clk28) cyc <= cyc + 1;

`ifdef FDC_WAIT_EN
  localparam int EXP_WAIT = 9;
`else
  localparam int EXP_WAIT = 0;
`endif

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { int a0; int is_rd; int data; int start; } exp_t;
  exp_t sb[$];

  // Access monitor, sampled on the falling edge
  logic prev_cs = 1'b1, prev_rd = 1'b1, prev_wr = 1'b1;
  bit   in_acc = 0, strobe_done = 0, saw_rd = 0, saw_wr = 0, wait_seen = 0;
  int   t_cs, t_sf, t_sr, oe_cnt, wait_cnt, a0_s, wdata, rdata, act_s;
  int   acc_cnt = 0;

  task automatic score(input int t_end);
    exp_t e;
    check("sb_available", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("acc_a0", a0_s, e.a0);
      check("acc_rd_strobe", 32'(saw_rd), e.is_rd);
      check("acc_wr_strobe", 32'(saw_wr), 32'(e.is_rd == 0));
      check("acc_setup", t_sf - t_cs, 2);
      check("acc_strobe_width", t_sr - t_sf, 7);
      check("acc_hold", t_end - t_sr, 2);
      check("acc_oe_cycles", oe_cnt, (e.is_rd != 0) ? 0 : 11);
      check("acc_wait_cycles", wait_cnt, EXP_WAIT);
      check("acc_data", (e.is_rd != 0) ? rdata : wdata, e.data);
      check("acc_active", act_s, e.is_rd);
      if (e.start >= 0) check("acc_start", t_cs, e.start);
    end
  endtask

  always @(negedge clk28) begin
    if (!wait_n) wait_seen = 1;
    if (rst) in_acc = 0;
    else begin
      if (prev_cs && !fdc_cs_n) begin
        in_acc = 1; strobe_done = 0; saw_rd = 0; saw_wr = 0;
        t_cs = cyc; a0_s = int'(fdc_a0); oe_cnt = 0; wait_cnt = 0;
        t_sf = -100; t_sr = -100; wdata = -1; rdata = -1; act_s = -1;
      end
      if (in_acc) begin
        if (fdc_d_oe) oe_cnt++;
        if (!strobe_done && !wait_n) wait_cnt++;
        if (prev_rd && !fdc_rd_n) begin saw_rd = 1; t_sf = cyc; end
        if (prev_wr && !fdc_wr_n) begin saw_wr = 1; t_sf = cyc; wdata = int'(fdc_d_out); end
        if ((!prev_rd && fdc_rd_n) || (!prev_wr && fdc_wr_n)) begin
          strobe_done = 1; t_sr = cyc; rdata = int'(d_out); act_s = int'(d_out_active);
        end
        if (!prev_cs && fdc_cs_n) begin
          in_acc = 0; acc_cnt++;
          $display("access #%0d: start=%0d a0=%0d rd=%0d wr=%0d", acc_cnt, t_cs, a0_s, saw_rd, saw_wr);
          score(cyc);
        end
      end
    end
    prev_cs = fdc_cs_n; prev_rd = fdc_rd_n; prev_wr = fdc_wr_n;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk28);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic drive(input logic [15:0] addr, input logic r, input logic w,
                       input logic [7:0] dat, input logic e);
    en = e; a = addr; rd = r; wr = w; d_in = dat; ioreq = 1'b1;
  endtask

  task automatic idle_bus();
    ioreq = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  logic [15:0] na [5] = '{16'h3FFD, 16'h3FFD, 16'h1FFD, 16'h7FFD, 16'h3FFF};
  bit          nen[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  bit          nrd[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int k, base;
    tick(3);
    check("rst_cs_n", fdc_cs_n, 1);
    check("rst_rd_n", fdc_rd_n, 1);
    check("rst_wr_n", fdc_wr_n, 1);
    check("rst_a0", fdc_a0, 0);
    check("rst_oe", fdc_d_oe, 0);
    check("rst_fdc_d_out", fdc_d_out, 8'h00);
    check("rst_d_out", d_out, 8'h00);
    check("rst_active", d_out_active, 0);
    check("rst_wait_n", wait_n, 1);
    rst = 1'b0; en = 1'b1;
    tick(2);

    // Read of #3FFD
    fdc_d_in = 8'h5A;
    sb.push_back('{a0: 1, is_rd: 1, data: 8'h5A, start: cyc + 1});
    drive(16'h3FFD, 1'b1, 1'b0, 8'h00, 1'b1);
    tick(20);
    fdc_d_in = 8'hFF;
    tick(1);
    check("read_hold_d_out", d_out, 8'h5A);
    check("read_hold_active", d_out_active, 1);
    idle_bus();
    tick(1);
    check("read_drop_active", d_out_active, 0);
    check("read_drop_d_out", d_out, 8'h5A);
    tick(20);

    // Write of #3FFD; d_in changes after capture
    sb.push_back('{a0: 1, is_rd: 0, data: 8'hC3, start: cyc + 1});
    drive(16'h3FFD, 1'b0, 1'b1, 8'hC3, 1'b1);
    tick(1);
    d_in = 8'h11;
    tick(4);
    idle_bus();
    tick(30);

    // Back-to-back reads of #2FFD: second queued, third dropped
    fdc_d_in = 8'h3C;
    base = acc_cnt;
    k = cyc + 1;
    sb.push_back('{a0: 0, is_rd: 1, data: 8'h3C, start: k});
    drive(16'h2FFD, 1'b1, 1'b0, 8'h00, 1'b1);
    tick(4); idle_bus();
    wait_until(k + 11);
    sb.push_back('{a0: 0, is_rd: 1, data: 8'h3C, start: k + 25});
    drive(16'h2FFD, 1'b1, 1'b0, 8'h00, 1'b1);
    tick(3); idle_bus();
    wait_until(k + 17);
    drive(16'h2FFD, 1'b1, 1'b0, 8'h00, 1'b1);
    tick(3); idle_bus();
    wait_until(k + 80);
    check("b2b_access_count", acc_cnt - base, 2);
    check("b2b_sb_empty", sb.size(), 0);

    // Reset during the third strobe cycle
    k = cyc + 1;
    drive(16'h3FFD, 1'b1, 1'b0, 8'h00, 1'b1);
    wait_until(k + 4);
    rst = 1'b1;
    tick(1);
    check("midrst_rd_n", fdc_rd_n, 1);
    check("midrst_cs_n", fdc_cs_n, 1);
    check("midrst_wait_n", wait_n, 1);
    check("midrst_active", d_out_active, 0);
    check("midrst_d_out", d_out, 8'h00);
    idle_bus();
    tick(1);
    rst = 1'b0;
    tick(2);
    sb.push_back('{a0: 1, is_rd: 1, data: 8'h3C, start: cyc + 1});
    drive(16'h3FFD, 1'b1, 1'b0, 8'h00, 1'b1);
    tick(15); idle_bus();
    tick(25);

    // Requests that must not start an access
    base = acc_cnt;
    wait_seen = 0;
    for (int i = 0; i < 5; i++) begin
      drive(na[i], nrd[i], 1'b1, 8'hA5, nen[i]);
      tick(3); idle_bus(); en = 1'b1;
      tick(30);
      check("noacc_count", acc_cnt - base, 0);
    end
    check("noacc_wait_seen", 32'(wait_seen), 0);
    check("noacc_cs_n", fdc_cs_n, 1);
    check("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fdc_bus_ctrl.md
# fdc_bus_ctrl

- Sequences CPU I/O accesses to the +3 floppy controller ports #2FFD (main status) and #3FFD (data) onto the external uPD765-compatible FDC bus.
- Generates the FDC chip-select, read and write strobes with programmable setup, strobe, hold and recovery times, and stalls the CPU with WAIT while a strobe is in progress.
- Latches FDC read data and presents it to the CPU read-data mux.
- Sits beside the I/O port decoder and replaces its raw single-cycle +3DOS strobes.

## Interface
Parameters:
- SETUP_CYC, 2, clk28 cycles of CS/A0 (and write data) valid before the strobe falls
- STROBE_CYC, 7, clk28 cycles the RD/WR strobe is held low (250 ns)
- HOLD_CYC, 2, clk28 cycles CS/A0/data held after the strobe rises
- RECOVERY_CYC, 14, minimum clk28 cycles from the end of HOLD to the next SETUP

Ports:
- clk28  in  1  system clock, 28 MHz
- rst  in  1  synchronous, active-high reset
- en  in  1  machine is +3; when low, no access is started
- ioreq  in  1  CPU I/O request
- rd  in  1  CPU read
- wr  in  1  CPU write
- a  in  16  CPU address
- d_in  in  8  CPU write data
- fdc_d_in  in  8  FDC data bus input
- fdc_d_out  out  8  FDC data bus output
- fdc_d_oe  out  1  FDC data bus output enable
- fdc_cs_n  out  1  FDC chip select
- fdc_a0  out  1  FDC register select (1 = data)
- fdc_rd_n  out  1  FDC read strobe
- fdc_wr_n  out  1  FDC write strobe
- d_out  out  8  latched read data to the CPU mux
- d_out_active  out  1  d_out is valid for the current I/O read
- wait_n  out  1  CPU WAIT request

## Operation
- Request decode: req = en && ioreq && a[15:13]==3'b001 && !a[1] && (rd ^ wr). Simultaneous rd and wr is not a request.
- An access starts on a rising edge of req (registered req_q low, req high) while the FSM is in IDLE.
- At the start, the block registers:
  - direction, from rd;
  - fdc_a0 = a[12];
  - write data = d_in.
- FSM states:
  - IDLE: all strobes inactive. A req edge moves to SETUP.
  - SETUP: fdc_cs_n=0. For a write, fdc_d_oe=1. Lasts SETUP_CYC cycles, then STROBE.
  - STROBE: fdc_rd_n=0 or fdc_wr_n=0, per direction. Lasts STROBE_CYC cycles. On the final cycle of a read, fdc_d_in is latched into d_out. Then HOLD.
  - HOLD: strobe inactive, fdc_cs_n, fdc_a0 and fdc_d_oe unchanged. Lasts HOLD_CYC cycles, then RECOVER.
  - RECOVER: fdc_cs_n=1, fdc_d_oe=0. Lasts RECOVERY_CYC cycles, then IDLE.
- A req edge arriving during HOLD or RECOVER is remembered in a one-deep pending flag.
  - The pending access starts in SETUP directly when RECOVER ends, using the address, direction and data captured at its edge.
  - A second pending edge before service is dropped.
- d_out_active = 1 from the cycle after the read latch until req falls, or until another access starts.
- d_out holds its last latched value indefinitely.
- The sequence always runs to completion once started, even if req drops.
- Counter: a single 4-bit down-counter, reloaded on each state entry. Parameters are limited to 1..15.
- Reset values:
  - FSM = IDLE, pending = 0, counter = 0;
  - fdc_cs_n = fdc_rd_n = fdc_wr_n = 1, fdc_a0 = 0, fdc_d_oe = 0;
  - fdc_d_out = 8'h00, d_out = 8'h00, d_out_active = 0, wait_n = 1.
- A reset asserted mid-access returns every output to its reset value on the next edge, including an immediate strobe release.

## Timing
- All outputs are registered; no combinational path from the inputs.
- With req rising before edge k, the following edges are counted from k:

| Signal | Asserted at | Released at |
|---|---|---|
| fdc_cs_n | k (low) | k+SETUP+STROBE+HOLD |
| strobe | k+SETUP (low) | k+SETUP+STROBE |

- Read latch occurs at edge k+SETUP+STROBE. d_out_active rises at the same edge.
- The default read therefore gives a strobe width of exactly 7 cycles and an earliest next SETUP at k+25.
- A pending access is delayed by the remaining recovery time only.

## Configuration
- FDC_WAIT_EN defined:
  - wait_n=0 from the edge that starts the access (or that captures it as pending) until the strobe rises, i.e. edge k+SETUP+STROBE;
  - for a pending access, wait_n stays low through HOLD, RECOVER and the new SETUP/STROBE.
- FDC_WAIT_EN undefined: wait_n is constant 1. Software must respect FDC timing; all other behaviour is identical.

## Test plan
- Read of #3FFD, fdc_d_in=8'h5A, defaults:
  - fdc_a0=1, fdc_rd_n low exactly 7 cycles after 2 setup cycles;
  - d_out=8'h5A with d_out_active=1 until ioreq drops;
  - wait_n low for 9 cycles (FDC_WAIT_EN).
- Write of #3FFD, d_in=8'hC3:
  - fdc_d_out=8'hC3 with fdc_d_oe=1 for 11 cycles;
  - fdc_wr_n low for 7 cycles;
  - fdc_rd_n stays 1, d_out_active stays 0.
- Back-to-back: a read of #2FFD followed by a second read edge 12 cycles later:
  - the second SETUP starts exactly 25 cycles after the first;
  - a third edge during that recovery is dropped.
- Reset asserted during the 3rd STROBE cycle: the next edge gives fdc_rd_n=1, fdc_cs_n=1, wait_n=1, d_out_active=0; FSM in IDLE.
- en=0 with an #3FFD write, and rd=wr=1 with en=1: no cs/strobe activity; wait_n stays 1.
- Address decode: #1FFD and #7FFD writes cause no access; #3FFD with a[1]=1 causes no access.
